// File: rtl/knn_dma_pkg.sv
// Shared types and constants for the KNN DMA schedulers (MM2S now, S2MM later).
package knn_dma_pkg;

    localparam int KNN_DMA_ADDR_WIDTH     = 32;
    localparam int KNN_DMA_LEN_WIDTH      = 32;
    localparam int KNN_DMA_BYTES_PER_BEAT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CPL   = 2'd3
    } knn_dma_state_e;

    function automatic logic knn_dma_is_aligned(input logic [63:0] addr,
                                                input int unsigned bytes_per_beat);
        return (addr % 64'(bytes_per_beat)) == 64'd0;
    endfunction

endpackage

// File: rtl/knn_dma_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant, with wrap-around.
module knn_dma_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // rot[j] is requester (last_grant+1+j) mod N
    logic [N-1:0] rot;
    logic         found;

    assign rot = N'({valid, valid} >> (int'(last_grant) + 1));

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found     = 1'b1;
                grant_idx = IW'((int'(last_grant) + 1 + j) % N);
            end
        end
        grant = found ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
        any   = found;
    end

endmodule

// File: rtl/knn_dma_mm2s_sched.sv
// Round-robin job scheduler in front of the KNN DMA MM2S read engine.
// Optional watchdog on the engine wait: define KNN_DMA_SCHED_WATCHDOG_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate, accept one job, route empty/misaligned to ST_CPL
// ST_START | one-cycle start pulse to the engine
// ST_WAIT  | wait for engine done/error (or watchdog expiry)
// ST_CPL   | one-cycle completion pulse to the owning requester
module knn_dma_mm2s_sched
    import knn_dma_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int ADDR_WIDTH     = KNN_DMA_ADDR_WIDTH,
    parameter  int LEN_WIDTH      = KNN_DMA_LEN_WIDTH,
    parameter  int BYTES_PER_BEAT = KNN_DMA_BYTES_PER_BEAT,
    parameter  int WDT_CYCLES     = 65536,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_length,
    output logic [NUM_REQ-1:0]            cpl_valid,
    output logic [NUM_REQ-1:0]            cpl_error,
    output logic                          mm2s_start,
    output logic [ADDR_WIDTH-1:0]         mm2s_addr,
    output logic [LEN_WIDTH-1:0]          mm2s_length,
    input  logic                          mm2s_done,
    input  logic                          mm2s_error,
    output logic                          busy,
    output logic [IW-1:0]                 grant_id,
    output logic                          wdt_timeout
);

    knn_dma_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic [IW-1:0]          last_grant_q;
    logic [IW-1:0]          grant_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   err_q;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic                   sel_empty;
    logic                   sel_misaligned;
    logic                   wdt_hit;

    knn_dma_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    assign sel_addr       = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len        = req_length[arb_idx*LEN_WIDTH +: LEN_WIDTH];
    assign sel_empty      = (sel_len == '0);
    assign sel_misaligned = !knn_dma_is_aligned(64'(sel_addr), BYTES_PER_BEAT);

`ifdef KNN_DMA_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(WDT_CYCLES) + 1;
    logic [CW-1:0] wdt_cnt_q;
    logic          wdt_q;

    assign wdt_hit = (state_q == ST_WAIT) && !mm2s_done && !mm2s_error &&
                     (wdt_cnt_q == CW'(WDT_CYCLES - 1));

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b0;
        end else begin
            if (state_q == ST_START)
                wdt_cnt_q <= '0;
            else if (state_q == ST_WAIT)
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
            if (wdt_hit)
                wdt_q <= 1'b1;
        end
    end

    assign wdt_timeout = wdt_q;
`else
    assign wdt_hit     = 1'b0;
    assign wdt_timeout = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = (sel_empty || sel_misaligned) ? ST_CPL : ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (mm2s_error || mm2s_done || wdt_hit) state_d = ST_CPL;
            ST_CPL:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job is latched at accept so requesters may change their inputs afterwards
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && arb_any) begin
                last_grant_q <= arb_idx;
                grant_q      <= arb_idx;
                addr_q       <= sel_addr;
                len_q        <= sel_len;
                err_q        <= !sel_empty && sel_misaligned;
            end else if (state_q == ST_WAIT) begin
                err_q        <= mm2s_error || wdt_hit;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        cpl_valid  = '0;
        cpl_error  = '0;
        mm2s_start = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (!M_AXI_ARESET) req_ready = arb_grant;
            end
            ST_START: mm2s_start = 1'b1;
            ST_CPL: begin
                cpl_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                cpl_error = err_q ? cpl_valid : '0;
            end
            default: ;
        endcase
    end

    assign mm2s_addr   = addr_q;
    assign mm2s_length = len_q;
    assign grant_id    = grant_q;

endmodule

// File: doc/knn_dma_mm2s_sched.md
Name: knn_dma_mm2s_sched

Overview:
- Round-robin scheduler that shares the single KNN DMA MM2S read engine between NUM_REQ requesters, e.g. the training-vector fetch and the query-vector fetch.
- Accepts one {addr, length} job per handshake and drives the engine's start/starting_addr/starting_length.
- Waits for transfer_done or error, then returns a per-requester completion pulse.
- Sits between the KNN control logic and the registered MM2S wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, byte address width; matches the MM2S engine
- LEN_WIDTH, 32, transfer length width in bytes
- BYTES_PER_BEAT, 8, AXI data width in bytes; sets the alignment check
- WDT_CYCLES, 65536, watchdog limit in clocks (used only with the optional feature)

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  job request per requester
- req_ready  out  NUM_REQ  job accepted this cycle (combinational, one-hot)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed start byte addresses; slice i belongs to requester i
- req_length  in  NUM_REQ*LEN_WIDTH  packed byte lengths
- cpl_valid  out  NUM_REQ  one-cycle completion pulse
- cpl_error  out  NUM_REQ  qualifies cpl_valid; 1 = job failed
- mm2s_start  out  1  one-cycle start pulse to the engine
- mm2s_addr  out  ADDR_WIDTH  engine start address
- mm2s_length  out  LEN_WIDTH  engine length
- mm2s_done  in  1  engine transfer_done
- mm2s_error  in  1  engine error
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NUM_REQ)  requester that owns the current job
- wdt_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: every output is 0. State is IDLE. The round-robin pointer last_grant is NUM_REQ-1, so requester 0 has priority first. Reset mid-job aborts silently with no cpl_valid; engine recovery belongs to the engine's own reset.
- States: IDLE, START, WAIT, CPL.
- IDLE:
  - The winner is the first requester with req_valid set, searching from last_grant+1 with wrap-around.
  - req_ready[winner]=1 in the same cycle, and the handshake completes there.
  - Latch addr, length and grant_id. Set last_grant to the winner.
  - If length==0 → CPL with error=0.
  - Else if addr % BYTES_PER_BEAT != 0 → CPL with error=1.
  - Else → START.
- START: mm2s_start=1 for exactly one cycle → WAIT. mm2s_addr and mm2s_length hold stable from START until leaving WAIT.
- WAIT:
  - mm2s_error → CPL with error=1.
  - mm2s_done without error → CPL with error=0.
  - Done and error in the same cycle: error wins.
- CPL: cpl_valid[grant_id]=1 and cpl_error[grant_id]=err for one cycle → IDLE.
- mm2s_done and mm2s_error are ignored outside WAIT.
- req_ready is 0 outside IDLE. Requesters hold valid, addr and length stable until ready.
- Job overhead: a non-empty job takes minimum 3 cycles plus engine latency, from the accept cycle to the cpl_valid cycle. An empty or misaligned job issues cpl_valid on the cycle after accept.
- Fairness: a requester that keeps valid high is served at least once every NUM_REQ jobs.

Optional Feature:
- Macro: KNN_DMA_SCHED_WATCHDOG_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDT_CYCLES-1 with no done or error, the block goes to CPL with error=1 and sets wdt_timeout.
  - wdt_timeout stays set until reset.
  - A later late mm2s_done is ignored.
- When undefined: no counter is built, WAIT has no limit, and wdt_timeout is tied to 0.

Decomposition:
- Shared package knn_dma_pkg holds:
  - the state encoding (IDLE/START/WAIT/CPL)
  - KNN_DMA_ADDR_WIDTH, KNN_DMA_LEN_WIDTH and KNN_DMA_BYTES_PER_BEAT constants
  - the alignment-check function
- Sub-module knn_dma_rr_arbiter: combinational pick from valid and last_grant, producing a one-hot grant and an index. Reused later for the S2MM side.

Test Plan:
- Single job: req0 addr 0x1000, len 2048. Expect req_ready[0] in the accept cycle, one mm2s_start with addr 0x1000 and len 2048. mm2s_done after 40 cycles → cpl_valid[0]=1, cpl_error[0]=0, one cycle later; busy falls next cycle.
- Contention: req0 and req1 valid continuously for 4 jobs each. Expect grant order 0,1,0,1,… and no requester serviced twice in a row.
- Zero length and misalignment: req1 len 0 → cpl_valid[1] with error 0 and no mm2s_start. req0 addr 0x1004 → cpl_error[0]=1 and no mm2s_start.
- Engine error: mm2s_error and mm2s_done asserted together in WAIT → cpl_error=1. A stray mm2s_done in IDLE is ignored.
- Reset mid-WAIT: assert M_AXI_ARESET → all outputs 0 immediately, busy 0, no cpl_valid. After release, requester 0 wins first.
- Watchdog (macro defined, WDT_CYCLES=16): no mm2s_done → cpl_error=1 and wdt_timeout=1 on cycle 16 of WAIT. A late mm2s_done afterwards has no effect.
